// File: rtl/uart_rx_frame_ctrl_if.sv
// Byte stream from the UART receiver plus the committed-bank read port and frame status.
// The consumer side (slave) takes bytes and answers reads; the master drives bytes and read addresses.
interface uart_rx_frame_ctrl_if #(
  parameter int AW = 4
);
  logic          iValid;
  logic [7:0]    iData;
  logic          rxAbort;
  logic [AW-1:0] rdAddr;
  logic [7:0]    rdData;
  logic          frameOk;
  logic          frameErr;
  logic          busy;
  logic [7:0]    errCnt;

  modport master (
    output iValid, iData, rdAddr,
    input  rxAbort, rdData, frameOk, frameErr, busy, errCnt
  );

  modport slave (
    input  iValid, iData, rdAddr,
    output rxAbort, rdData, frameOk, frameErr, busy, errCnt
  );
endinterface

// File: rtl/uart_rx_frame_ctrl.sv
// Sync hunt, fixed-length payload + checksum collection, inter-byte timeout and double-buffered commit.
// frameOk/frameErr arrive 2 cycles after the checksum byte; no backpressure, one byte per iValid rising edge.
module uart_rx_frame_ctrl #(
  parameter logic [7:0] SYNC_BYTE   = 8'hA5,
  parameter int         PAYLOAD_LEN = 8,
  parameter int         TIMEOUT     = 5000,
  parameter int         AW          = 4
) (
  input logic               clk,
  input logic               rst,
  uart_rx_frame_ctrl_if.slave bus
);
  localparam int TW    = $clog2(TIMEOUT + 1);
  localparam int DEPTH = 2 ** AW;

  typedef enum logic [2:0] {HUNT, PAYLOAD, CHECK, COMMIT, ERR} state_t;

  state_t        state, stateNxt;
  logic          iValidQ;
  logic [AW-1:0] idx;
  logic [7:0]    sum;
  logic [TW-1:0] tmo;
  logic          active;
  logic [7:0]    bank [2][DEPTH];
  logic [1:0]    abortCnt;
  logic [7:0]    rdDataQ;
  logic          frameOkQ, frameErrQ;
  logic [7:0]    errCntQ;

  logic acc, startFrame, wrEn, tmoHit, swap, errEv;

  assign acc = bus.iValid & ~iValidQ;

  always_comb begin
    stateNxt   = state;
    startFrame = 1'b0;
    wrEn       = 1'b0;
    tmoHit     = 1'b0;
    swap       = 1'b0;
    errEv      = 1'b0;
    case (state)
      HUNT: begin
        if (acc && bus.iData == SYNC_BYTE) begin
          startFrame = 1'b1;
          stateNxt   = PAYLOAD;
        end
      end
      PAYLOAD: begin
        // A byte landing on the timeout cycle takes priority over the timeout
        if (acc) begin
          wrEn = 1'b1;
          if (idx == AW'(PAYLOAD_LEN - 1)) stateNxt = CHECK;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          tmoHit   = 1'b1;
          stateNxt = ERR;
        end
      end
      CHECK: begin
        if (acc) begin
          stateNxt = (bus.iData == sum) ? COMMIT : ERR;
        end else if (tmo == TW'(TIMEOUT - 1)) begin
          tmoHit   = 1'b1;
          stateNxt = ERR;
        end
      end
      COMMIT: begin
        swap     = 1'b1;
        stateNxt = HUNT;
      end
      ERR: begin
        errEv    = 1'b1;
        stateNxt = HUNT;
      end
      default: stateNxt = HUNT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= HUNT;
      iValidQ   <= 1'b0;
      idx       <= '0;
      sum       <= '0;
      tmo       <= '0;
      active    <= 1'b0;
      abortCnt  <= '0;
      rdDataQ   <= '0;
      frameOkQ  <= 1'b0;
      frameErrQ <= 1'b0;
      errCntQ   <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int a = 0; a < DEPTH; a++) begin
          bank[b][a] <= '0;
        end
      end
    end else begin
      state     <= stateNxt;
      iValidQ   <= bus.iValid;
      frameOkQ  <= swap;
      frameErrQ <= errEv;

      if (startFrame) begin
        idx <= '0;
        sum <= '0;
      end else if (wrEn) begin
        // Payload always lands in the shadow bank; committed data stays readable
        bank[~active][idx] <= bus.iData;
        sum                <= sum + bus.iData;
        idx                <= idx + AW'(1);
      end

      if (acc || startFrame) tmo <= '0;
      else if (state == PAYLOAD || state == CHECK) tmo <= tmo + TW'(1);

      if (swap) active <= ~active;
      if (errEv && errCntQ != 8'hFF) errCntQ <= errCntQ + 8'd1;

      if (tmoHit) abortCnt <= 2'd2;
      else if (abortCnt != 2'd0) abortCnt <= abortCnt - 2'd1;

      rdDataQ <= bank[active][bus.rdAddr];
    end
  end

  assign bus.rxAbort  = (abortCnt != 2'd0);
  assign bus.rdData   = rdDataQ;
  assign bus.frameOk  = frameOkQ;
  assign bus.frameErr = frameErrQ;
  assign bus.busy     = (state != HUNT);
  assign bus.errCnt   = errCntQ;
endmodule

// File: tb/tb_uart_rx_frame_ctrl.sv
// Frame table plus hand-written timeout, reset and saturation sequences; pulses checked against a queue.
module tb_uart_rx_frame_ctrl;
  localparam logic [7:0] SYNC = 8'hA5;
  localparam int TMO = 5000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_rx_frame_ctrl_if #(.AW(4)) ifc ();

  uart_rx_frame_ctrl #(
    .SYNC_BYTE(SYNC), .PAYLOAD_LEN(8), .TIMEOUT(TMO), .AW(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(ifc)
  );

  typedef struct packed {
    logic [7:0][7:0] pay;
    logic [7:0]      cks;
    logic [3:0]      hold;
    logic            ok;
  } frame_t;

  typedef struct {
    bit         isOk;
    logic [7:0] cnt;
  } ev_t;

  frame_t     tbl [5];
  ev_t        expQ [$];
  logic [7:0] model [8];
  int         expErr = 0;
  int         checks = 0;
  int         failures = 0;
  int         cyc = 0;
  int         lastAcc = 0;
  int         abortN = 0;
  int         abortFirst = 0;

  always @(posedge clk) cyc++;

  // Scoreboard side: every frame pulse must match the oldest expected event
  always @(negedge clk) begin
    if (rst && (ifc.frameOk || ifc.frameErr)) begin
      checks++;
      if (expQ.size() == 0) begin
        failures++;
        $display("FAIL unexpected_pulse ok=%0b err=%0b cyc=%0d", ifc.frameOk, ifc.frameErr, cyc);
      end else begin
        ev_t e;
        e = expQ.pop_front();
        if (ifc.frameOk !== e.isOk || ifc.frameErr !== !e.isOk || ifc.errCnt !== e.cnt) begin
          failures++;
          $display("FAIL frame_pulse got ok=%0b err=%0b errCnt=%0d want ok=%0b errCnt=%0d",
                   ifc.frameOk, ifc.frameErr, ifc.errCnt, e.isOk, e.cnt);
        end
      end
    end
    if (rst && ifc.rxAbort) begin
      if (abortN == 0) abortFirst = cyc;
      abortN++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] csum(input logic [7:0][7:0] p);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < 8; i++) s = s + p[i];
    return s;
  endfunction

  task automatic sendByte(input logic [7:0] b, input int hold);
    lastAcc = cyc + 1;
    ifc.iValid = 1'b1;
    ifc.iData  = b;
    repeat (hold) @(negedge clk);
    ifc.iValid = 1'b0;
    @(negedge clk);
  endtask

  task automatic expectEv(input bit ok, input logic [7:0][7:0] p);
    ev_t e;
    if (ok) begin
      for (int i = 0; i < 8; i++) model[i] = p[i];
    end else if (expErr < 255) begin
      expErr++;
    end
    e.isOk = ok;
    e.cnt  = 8'(expErr);
    expQ.push_back(e);
  endtask

  task automatic sendFrame(input frame_t f);
    sendByte(SYNC, int'(f.hold));
    for (int i = 0; i < 8; i++) sendByte(f.pay[i], int'(f.hold));
    expectEv(f.ok, f.pay);
    sendByte(f.cks, int'(f.hold));
  endtask

  task automatic drain();
    int n = 0;
    while (expQ.size() != 0 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("drain_pending", expQ.size(), 0);
  endtask

  task automatic readBack(input string tag);
    for (int i = 0; i < 8; i++) begin
      ifc.rdAddr = 4'(i);
      @(negedge clk);
      chk($sformatf("%s_rd%0d", tag, i), ifc.rdData, model[i]);
    end
  endtask

  task automatic chkIdle(input string tag);
    chk({tag, "_rxAbort"}, ifc.rxAbort, 0);
    chk({tag, "_frameOk"}, ifc.frameOk, 0);
    chk({tag, "_frameErr"}, ifc.frameErr, 0);
    chk({tag, "_busy"}, ifc.busy, 0);
    chk({tag, "_errCnt"}, ifc.errCnt, 0);
    chk({tag, "_rdData"}, ifc.rdData, 0);
  endtask

  initial begin
    frame_t f;
    int     e;
    int     n;

    for (int i = 0; i < 8; i++) begin
      tbl[0].pay[i] = 8'(i + 1);
      tbl[1].pay[i] = 8'(i + 1);
      tbl[3].pay[i] = 8'hFF;
      tbl[4].pay[i] = 8'($urandom_range(0, 255));
    end
    tbl[0].cks = 8'h24; tbl[0].hold = 4'd1; tbl[0].ok = 1'b1;
    tbl[1].cks = 8'h25; tbl[1].hold = 4'd1; tbl[1].ok = 1'b0;
    tbl[2].pay = {8'h40, 8'h30, 8'h20, 8'h10, 8'hFF, 8'h00, 8'hA5, 8'hA5};
    tbl[2].cks = 8'hE9; tbl[2].hold = 4'd3; tbl[2].ok = 1'b1;
    tbl[3].cks = 8'hF8; tbl[3].hold = 4'd2; tbl[3].ok = 1'b1;
    tbl[4].cks = csum(tbl[4].pay); tbl[4].hold = 4'd1; tbl[4].ok = 1'b1;
    for (int i = 0; i < 8; i++) model[i] = 8'h00;

    rst = 1'b0;
    ifc.iValid = 1'b0;
    ifc.iData  = 8'h00;
    ifc.rdAddr = 4'd0;
    repeat (3) @(negedge clk);
    chkIdle("reset");
    rst = 1'b1;
    @(negedge clk);

    sendByte(8'h00, 1);
    sendByte(8'h5A, 2);
    chk("hunt_junk_busy", ifc.busy, 0);

    for (int t = 0; t < 5; t++) begin
      sendByte(SYNC, int'(tbl[t].hold));
      chk($sformatf("t%0d_busy", t), ifc.busy, 1);
      for (int i = 0; i < 8; i++) sendByte(tbl[t].pay[i], int'(tbl[t].hold));
      expectEv(tbl[t].ok, tbl[t].pay);
      sendByte(tbl[t].cks, int'(tbl[t].hold));
      drain();
      chk($sformatf("t%0d_errCnt", t), ifc.errCnt, expErr);
      chk($sformatf("t%0d_busy_after", t), ifc.busy, 0);
      readBack($sformatf("t%0d", t));
    end
    chk("no_abort_on_cks_err", abortN, 0);

    // Silence after the third payload byte
    sendByte(SYNC, 1);
    for (int i = 0; i < 3; i++) sendByte(8'(8'h30 + i), 1);
    e = lastAcc;
    abortN = 0;
    expectEv(1'b0, '0);
    n = 0;
    while (!ifc.frameErr && n < TMO + 20) begin
      @(negedge clk);
      n++;
    end
    chk("tmo_err_cycle", cyc, e + TMO + 1);
    chk("tmo_busy", ifc.busy, 0);
    repeat (3) @(negedge clk);
    chk("tmo_abort_len", abortN, 2);
    chk("tmo_abort_start", abortFirst, e + TMO);
    drain();
    readBack("tmo");

    // Byte landing exactly on the timeout cycle keeps the frame alive
    abortN = 0;
    for (int i = 0; i < 8; i++) f.pay[i] = 8'(8'h10 * (i + 1));
    f.cks = csum(f.pay);
    sendByte(SYNC, 1);
    sendByte(f.pay[0], 1);
    sendByte(f.pay[1], 1);
    e = lastAcc;
    while (cyc < e + TMO - 1) @(negedge clk);
    sendByte(f.pay[2], 1);
    chk("edge_acc_cycle", lastAcc, e + TMO);
    chk("edge_busy", ifc.busy, 1);
    for (int i = 3; i < 8; i++) sendByte(f.pay[i], 1);
    expectEv(1'b1, f.pay);
    sendByte(f.cks, 1);
    drain();
    chk("edge_no_abort", abortN, 0);
    readBack("edge");

    // Reset in the middle of a payload
    sendByte(SYNC, 1);
    for (int i = 0; i < 3; i++) sendByte(8'h77, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chkIdle("midrst");
    for (int i = 0; i < 8; i++) model[i] = 8'h00;
    expErr = 0;
    rst = 1'b1;
    readBack("midrst");
    sendFrame(tbl[0]);
    drain();
    readBack("post_rst");

    // Saturation of the error counter
    f = tbl[1];
    for (int k = 0; k < 256; k++) sendFrame(f);
    drain();
    chk("errCnt_sat", ifc.errCnt, 255);
    readBack("sat");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
